dot_product_engine: RTL and testbench

DOT_PRODUCT_ENGINE -- requirements
Module: dot_product_engine

---
 rtl/dot_product_engine_if.sv | 32 +++
 rtl/dot_product_engine.sv | 142 ++++++++++++++
 tb/tb_dot_product_engine.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dot_product_engine_if.sv
// Operand/result handshake bundle for dot_product_engine; master drives operands, slave is the engine.
interface dot_product_engine_if #(
  parameter int DATA_W = 32,
  parameter int ACC_W  = 32,
  parameter int LANES  = 4,
  parameter int LEN_W  = 8
) ();

  logic                    start;
  logic [LEN_W-1:0]        len;
  logic                    in_valid;
  logic                    in_ready;
  logic [LANES*DATA_W-1:0] a_vec;
  logic [LANES*DATA_W-1:0] b_vec;
  logic [LANES-1:0]        lane_mask;
  logic [ACC_W-1:0]        result;
  logic                    result_valid;
  logic                    result_ready;
  logic                    busy;
  logic                    overflow;

  modport master (
    output start, len, in_valid, a_vec, b_vec, lane_mask, result_ready,
    input  in_ready, result, result_valid, busy, overflow
  );

  modport slave (
    input  start, len, in_valid, a_vec, b_vec, lane_mask, result_ready,
    output in_ready, result, result_valid, busy, overflow
  );

endinterface

// File: rtl/dot_product_engine.sv
// Multi-beat unsigned dot product (multiply stage + accumulate stage); DOT_PRODUCT_SAT_EN selects saturate vs wrap.
// Result valid 3 cycles after the last beat; in_ready only while accumulating, result held until result_ready.
module dot_product_engine #(
  parameter int DATA_W = 32,
  parameter int ACC_W  = 32,
  parameter int LANES  = 4,
  parameter int LEN_W  = 8
) (
  input logic                 clk,
  input logic                 reset,
  dot_product_engine_if.slave dp
);

  localparam int PROD_W = 2 * DATA_W;
  localparam int BASE_W = (ACC_W > PROD_W) ? ACC_W : PROD_W;
  localparam int SUM_W  = BASE_W + $clog2(LANES) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   cnt_q;
  logic               drain_q;
  logic [PROD_W-1:0]  prod_d [LANES];
  logic [PROD_W-1:0]  prod_q [LANES];
  logic               p_vld_q;
  logic [ACC_W-1:0]   acc_q;
  logic               ovf_q;
  logic [SUM_W-1:0]   sum_d;
  logic               ovf_now;
  logic               beat_acc;
  logic               start_acc;
  logic               last_beat;

  assign beat_acc  = (state_q == ACCUM) && dp.in_valid;
  assign start_acc = dp.start && ((state_q == IDLE) || ((state_q == DONE) && dp.result_ready));
  assign last_beat = beat_acc && (cnt_q == (len_q - LEN_W'(1)));

  // Masked lanes contribute a zero product so they can never raise overflow.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign prod_d[i] = dp.lane_mask[i]
                     ? PROD_W'(dp.a_vec[i*DATA_W +: DATA_W]) * PROD_W'(dp.b_vec[i*DATA_W +: DATA_W])
                     : '0;
  end

  // Wide enough that any bit above ACC_W flags a product or carry overflow.
  always_comb begin
    sum_d = SUM_W'(acc_q);
    for (int i = 0; i < LANES; i++) begin
      sum_d = sum_d + SUM_W'(prod_q[i]);
    end
  end

  assign ovf_now = |sum_d[SUM_W-1:ACC_W];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_acc) begin
          state_d = (dp.len == '0) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (last_beat) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (drain_q) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (start_acc) begin
          state_d = (dp.len == '0) ? DONE : ACCUM;
        end else if (dp.result_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      len_q   <= '0;
      cnt_q   <= '0;
      drain_q <= 1'b0;
      p_vld_q <= 1'b0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        prod_q[i] <= '0;
      end
    end else begin
      drain_q <= (state_q == DRAIN) ? ~drain_q : 1'b0;
      p_vld_q <= beat_acc;
      if (beat_acc) begin
        cnt_q <= cnt_q + LEN_W'(1);
        for (int i = 0; i < LANES; i++) begin
          prod_q[i] <= prod_d[i];
        end
      end
      // Start is only accepted in IDLE/DONE, where the product pipeline is already empty.
      if (start_acc) begin
        len_q <= dp.len;
        cnt_q <= '0;
        acc_q <= '0;
        ovf_q <= 1'b0;
      end else if (p_vld_q) begin
`ifdef DOT_PRODUCT_SAT_EN
        acc_q <= (ovf_q || ovf_now) ? {ACC_W{1'b1}} : sum_d[ACC_W-1:0];
`else
        acc_q <= sum_d[ACC_W-1:0];
`endif
        ovf_q <= ovf_q | ovf_now;
      end
    end
  end

  assign dp.in_ready     = (state_q == ACCUM);
  assign dp.busy         = (state_q != IDLE);
  assign dp.result_valid = (state_q == DONE);
  assign dp.result       = acc_q;
  assign dp.overflow     = ovf_q;

endmodule

// File: tb/tb_dot_product_engine.sv
// Randomized bench for dot_product_engine with a wide-arithmetic reference model and a result monitor.
module tb_dot_product_engine;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int NL = 4;
  localparam int LW = 8;

  typedef struct packed {
    logic [AW-1:0] r;
    logic          o;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  dot_product_engine_if #(.DATA_W(DW), .ACC_W(AW), .LANES(NL), .LEN_W(LW)) dp ();

  dot_product_engine #(.DATA_W(DW), .ACC_W(AW), .LANES(NL), .LEN_W(LW)) dut (
    .clk   (clk),
    .reset (reset),
    .dp    (dp)
  );

  int          errors = 0;
  int          checks = 0;
  exp_t        exp_q[$];
  logic [DW-1:0] a_arr [16][NL];
  logic [DW-1:0] b_arr [16][NL];
  logic [NL-1:0] m_arr [16];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // Unbounded-precision reference: exact sum per beat, then wrap or clamp to ACC_W.
  function automatic exp_t model(input int n);
    logic [127:0] acc;
    logic [127:0] s;
    logic [127:0] t;
    exp_t e;
    acc = '0;
    e.o = 1'b0;
    for (int k = 0; k < n; k++) begin
      s = '0;
      for (int i = 0; i < NL; i++) begin
        if (m_arr[k][i]) s = s + 128'(a_arr[k][i]) * 128'(b_arr[k][i]);
      end
      t = acc + s;
`ifdef DOT_PRODUCT_SAT_EN
      if (e.o || t > 128'hFFFF_FFFF) begin
        e.o = 1'b1;
        acc = 128'hFFFF_FFFF;
      end else begin
        acc = t;
      end
`else
      if (t > 128'hFFFF_FFFF) e.o = 1'b1;
      acc = t & 128'hFFFF_FFFF;
`endif
    end
    e.r = acc[AW-1:0];
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    dp.start        = 1'b0;
    dp.len          = '0;
    dp.in_valid     = 1'b0;
    dp.a_vec        = '0;
    dp.b_vec        = '0;
    dp.lane_mask    = '0;
    dp.result_ready = 1'b0;
  endtask

  task automatic gen(input int n, input int kind);
    for (int k = 0; k < n; k++) begin
      m_arr[k] = ($urandom_range(0, 15) == 0) ? 4'h0 : NL'($urandom_range(0, 15));
      for (int i = 0; i < NL; i++) begin
        a_arr[k][i] = (kind != 0) ? DW'($urandom) : DW'($urandom_range(0, 255));
        b_arr[k][i] = (kind != 0) ? DW'($urandom) : DW'($urandom_range(0, 255));
      end
    end
  endtask

  task automatic drive_beat(input int k);
    logic [NL*DW-1:0] av;
    logic [NL*DW-1:0] bv;
    for (int i = 0; i < NL; i++) begin
      av[i*DW +: DW] = a_arr[k][i];
      bv[i*DW +: DW] = b_arr[k][i];
    end
    dp.in_valid  = 1'b1;
    dp.a_vec     = av;
    dp.b_vec     = bv;
    dp.lane_mask = m_arr[k];
  endtask

  task automatic begin_op(input int n);
    dp.start = 1'b1;
    dp.len   = LW'(n);
    exp_q.push_back(model(n));
    step();
    dp.start = 1'b0;
  endtask

  // Entered just after the start edge; returns at the negedge of the first DONE cycle.
  task automatic feed(input int n, input int gap, input string tag);
    int lat;
    for (int k = 0; k < n; k++) begin
      if (k > 0) begin
        for (int g = 0; g < gap; g++) begin
          dp.in_valid = 1'b0;
          dp.a_vec    = {NL{32'hDEAD_BEEF}};
          @(negedge clk);
          chk({tag, " gap_in_ready"}, dp.in_ready, 1);
          step();
        end
      end
      drive_beat(k);
      @(negedge clk);
      chk({tag, " in_ready"}, dp.in_ready, 1);
      chk({tag, " busy"}, dp.busy, 1);
      step();
    end
    dp.in_valid = 1'b0;
    lat = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (dp.result_valid) begin
        lat = c;
        break;
      end
    end
    chk({tag, " latency"}, lat, (n == 0) ? 1 : 3);
    chk({tag, " done_in_ready"}, dp.in_ready, 0);
    chk({tag, " done_busy"}, dp.busy, 1);
  endtask

  task automatic finish_op(input int delay, input bit chain, input int next_n);
    repeat ((delay < 1) ? 1 : delay) step();
    dp.result_ready = 1'b1;
    if (chain) begin
      dp.start = 1'b1;
      dp.len   = LW'(next_n);
      exp_q.push_back(model(next_n));
    end
    step();
    dp.result_ready = 1'b0;
    dp.start        = 1'b0;
    if (!chain) begin
      @(negedge clk);
      chk("post_busy", dp.busy, 0);
      chk("post_valid", dp.result_valid, 0);
      chk("post_in_ready", dp.in_ready, 0);
      step();
    end
  endtask

  exp_t cur;
  bit   have = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      have = 1'b0;
    end else if (dp.result_valid) begin
      if (!have) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL mon_unexpected: got result %0h with no pending operation", dp.result);
        end else begin
          cur = exp_q.pop_front();
          if (dp.result !== cur.r || dp.overflow !== cur.o) begin
            errors++;
            $display("FAIL mon_result: got %0h/%0b want %0h/%0b", dp.result, dp.overflow, cur.r, cur.o);
          end
        end
        have = 1'b1;
      end else begin
        chk("hold_result", dp.result, cur.r);
        chk("hold_overflow", dp.overflow, cur.o);
      end
      if (dp.result_ready) have = 1'b0;
    end else if (have) begin
      checks++;
      errors++;
      $display("FAIL mon_valid_dropped: got valid 0 want 1");
      have = 1'b0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   n;
    int   nn;
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    @(negedge clk);
    chk("rst_in_ready", dp.in_ready, 0);
    chk("rst_busy", dp.busy, 0);
    chk("rst_valid", dp.result_valid, 0);
    chk("rst_result", dp.result, 0);
    chk("rst_overflow", dp.overflow, 0);
    step();
    reset = 1'b0;
    step();

    // Two beats, all lanes enabled, b all ones.
    for (int k = 0; k < 2; k++) begin
      m_arr[k] = 4'hF;
      for (int i = 0; i < NL; i++) begin
        a_arr[k][i] = DW'(k * 4 + i + 1);
        b_arr[k][i] = 32'd1;
      end
    end
    e = model(2);
    chk("model_basic_result", e.r, 36);
    chk("model_basic_ovf", e.o, 0);
    begin_op(2);
    feed(2, 0, "basic");
    chk("basic_result", dp.result, 36);
    chk("basic_ovf", dp.overflow, 0);
    finish_op(2, 1'b0, 0);

    // Zero-length operation clears the previous result.
    begin_op(0);
    feed(0, 0, "len0");
    chk("len0_result", dp.result, 0);
    chk("len0_ovf", dp.overflow, 0);
    finish_op(1, 1'b0, 0);

    // Single-lane overflow.
    gen(1, 1);
    m_arr[0]    = 4'h1;
    a_arr[0][0] = 32'hFFFF_FFFF;
    b_arr[0][0] = 32'd2;
    e = model(1);
`ifdef DOT_PRODUCT_SAT_EN
    chk("model_ovf_result", e.r, 32'hFFFF_FFFF);
`else
    chk("model_ovf_result", e.r, 32'hFFFF_FFFE);
`endif
    begin_op(1);
    feed(1, 0, "ovf");
    chk("ovf_result", dp.result, e.r);
    chk("ovf_flag", dp.overflow, 1);
    finish_op(1, 1'b0, 0);

    // Gapped beats with lanes 1 and 3 masked off.
    for (int k = 0; k < 3; k++) begin
      m_arr[k]    = 4'b0101;
      a_arr[k][0] = DW'(k + 1);
      a_arr[k][1] = 32'd99;
      a_arr[k][2] = DW'(k + 2);
      a_arr[k][3] = 32'hFFFF_0077;
      b_arr[k][0] = 32'd3;
      b_arr[k][1] = 32'd55;
      b_arr[k][2] = 32'd4;
      b_arr[k][3] = 32'hFFFF_0066;
    end
    e = model(3);
    chk("model_mask_result", e.r, 54);
    begin_op(3);
    feed(3, 5, "mask");
    chk("mask_result", dp.result, 54);
    chk("mask_ovf", dp.overflow, 0);
    finish_op(1, 1'b0, 0);

    // Reset in the middle of accumulation, competing with every other input.
    gen(4, 1);
    begin_op(4);
    drive_beat(0);
    step();
    void'(exp_q.pop_back());
    reset           = 1'b1;
    dp.start        = 1'b1;
    dp.len          = LW'(2);
    dp.result_ready = 1'b1;
    step();
    @(negedge clk);
    chk("mid_rst_in_ready", dp.in_ready, 0);
    chk("mid_rst_busy", dp.busy, 0);
    chk("mid_rst_valid", dp.result_valid, 0);
    chk("mid_rst_result", dp.result, 0);
    chk("mid_rst_overflow", dp.overflow, 0);
    step();
    reset = 1'b0;
    idle_inputs();
    step();
    gen(4, 0);
    begin_op(4);
    feed(4, 1, "after_rst");
    finish_op(1, 1'b0, 0);

    // Result held for 10 cycles, then consumed together with the next start.
    gen(2, 0);
    begin_op(2);
    feed(2, 0, "hold");
    gen(3, 0);
    finish_op(10, 1'b1, 3);
    feed(3, 0, "chained");
    finish_op(1, 1'b0, 0);

    n = $urandom_range(0, 6);
    gen(n, $urandom_range(0, 1));
    begin_op(n);
    for (int it = 0; it < 40; it++) begin
      feed(n, $urandom_range(0, 2), "rnd");
      if (it < 39 && $urandom_range(0, 1) == 1) begin
        nn = $urandom_range(0, 6);
        gen(nn, $urandom_range(0, 1));
        finish_op($urandom_range(0, 3), 1'b1, nn);
        n = nn;
      end else begin
        finish_op($urandom_range(0, 3), 1'b0, 0);
        if (it < 39) begin
          n = $urandom_range(0, 6);
          gen(n, $urandom_range(0, 1));
          begin_op(n);
        end
      end
    end

    chk("pending_results", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
